// File: rtl/bpu_pkg.sv
// Shared types for the branch-prediction unit: BTB update controller state and update record.
package bpu_pkg;

    typedef enum logic {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } btb_uc_state_e;

    typedef struct packed {
        logic [29:0] pc;
        logic [29:0] bta;
        logic [1:0]  br_type;
    } btb_upd_t;

    // Branch-type value written into invalidated entries.
    localparam logic [1:0] BR_PC_RELATIVE = 2'd0;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the pointer (cyclic).
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i_req,
    input  logic         i_en,
    output logic [N-1:0] o_grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_idx;
    logic [PW-1:0] w_gidx;
    logic          w_found;

    always_comb begin
        o_grant = '0;
        w_idx   = '0;
        w_gidx  = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            w_idx = PW'((int'(r_ptr) + k) % N);
            if (i_en && !w_found && i_req[w_idx]) begin
                w_found = 1'b1;
                w_gidx  = w_idx;
            end
        end
        if (w_found) begin
            o_grant[w_gidx] = 1'b1;
        end
    end

    // Pointer moves just past the winner so it has lowest priority next time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= (w_gidx == PW'(N - 1)) ? '0 : w_gidx + 1'b1;
        end
    end

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB write-port scheduler: round-robin intake of branch updates into a small FIFO drained
// one per cycle, plus the full-BTB invalidation sweep after reset and on flush.
module btb_update_ctrl
    import bpu_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int FIFO_DEPTH = 4,
    parameter int N_REQ      = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic [N_REQ-1:0]       req_valid_i,
    output logic [N_REQ-1:0]       req_ready_o,
    input  logic [N_REQ-1:0][29:0] req_pc_i,
    input  logic [N_REQ-1:0][29:0] req_bta_i,
    input  logic [N_REQ-1:0][1:0]  req_br_type_i,
    output logic                   busy_o,
    output logic                   wr_en_o,
    output logic                   wr_valid_o,
    output logic [29:0]            wr_pc_o,
    output logic [29:0]            wr_bta_o,
    output logic [1:0]             wr_br_type_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] SWEEP_LAST = '1;

    btb_uc_state_e         r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_sweep_cnt, w_cnt_nxt;
    btb_upd_t              r_mem [FIFO_DEPTH];
    logic [PTR_W:0]        r_wr_ptr, r_rd_ptr;

    logic                  w_empty, w_full;
    logic                  w_arb_en, w_push, w_pop;
    logic [N_REQ-1:0]      w_grant;
    btb_upd_t              w_in, w_head;

    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                      (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    // A full FIFO refuses requests even while its head drains: no bypass path.
    assign w_arb_en = (r_state == RUN) && !flush_i && !w_full;
    assign w_push   = |w_grant;
    assign w_pop    = (r_state == RUN) && !flush_i && !w_empty;
    assign w_head   = r_mem[r_rd_ptr[PTR_W-1:0]];

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .i_req   (req_valid_i),
        .i_en    (w_arb_en),
        .o_grant (w_grant)
    );

    always_comb begin
        w_in = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_grant[k]) begin
                w_in = {req_pc_i[k], req_bta_i[k], req_br_type_i[k]};
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_sweep_cnt;
        req_ready_o  = w_grant;
        busy_o       = 1'b0;
        wr_en_o      = 1'b0;
        wr_valid_o   = 1'b0;
        wr_pc_o      = '0;
        wr_bta_o     = '0;
        wr_br_type_o = BR_PC_RELATIVE;
        if (r_state == SWEEP) begin
            busy_o                  = 1'b1;
            wr_en_o                 = 1'b1;
            wr_pc_o[ADDR_WIDTH:1]   = r_sweep_cnt;
            if (flush_i) begin
                w_cnt_nxt = '0;
            end else if (r_sweep_cnt == SWEEP_LAST) begin
                w_cnt_nxt   = '0;
                w_state_nxt = RUN;
            end else begin
                w_cnt_nxt = r_sweep_cnt + 1'b1;
            end
        end else begin
            wr_en_o      = w_pop;
            wr_valid_o   = 1'b1;
            wr_pc_o      = w_head.pc;
            wr_bta_o     = w_head.bta;
            wr_br_type_o = w_head.br_type;
            if (flush_i) begin
                w_state_nxt = SWEEP;
                w_cnt_nxt   = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= SWEEP;
            r_sweep_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sweep_cnt <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if ((r_state == RUN) && flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= w_in;
        end
    end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Randomized bench for btb_update_ctrl against a queue-based reference model.
module tb_btb_update_ctrl;

    localparam int AW = 3;
    localparam int D  = 4;
    localparam int N  = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                flush_i = 1'b0;
    logic [N-1:0]        req_valid_i = '0;
    logic [N-1:0]        req_ready_o;
    logic [N-1:0][29:0]  req_pc_i = '0;
    logic [N-1:0][29:0]  req_bta_i = '0;
    logic [N-1:0][1:0]   req_br_type_i = '0;
    logic                busy_o, wr_en_o, wr_valid_o;
    logic [29:0]         wr_pc_o, wr_bta_o;
    logic [1:0]          wr_br_type_o;

    btb_update_ctrl #(.ADDR_WIDTH(AW), .FIFO_DEPTH(D), .N_REQ(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_pc_i      (req_pc_i),
        .req_bta_i     (req_bta_i),
        .req_br_type_i (req_br_type_i),
        .busy_o        (busy_o),
        .wr_en_o       (wr_en_o),
        .wr_valid_o    (wr_valid_o),
        .wr_pc_o       (wr_pc_o),
        .wr_bta_o      (wr_bta_o),
        .wr_br_type_o  (wr_br_type_o)
    );

    always #5 clk = ~clk;

    // Reference model: sweep flag and count, pending updates {pc,bta,type}, round-robin start.
    logic [61:0] exp_q[$];
    bit          m_sweep;
    int          m_cnt;
    int          m_rr;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sweep = 1'b1;
        m_cnt   = 0;
        m_rr    = 0;
        exp_q.delete();
    endtask

    task automatic check_reset_outputs();
        check("rst_ready", 64'(req_ready_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd1);
        check("rst_wr_en", 64'(wr_en_o), 64'd1);
        check("rst_wr_valid", 64'(wr_valid_o), 64'd0);
        check("rst_wr_pc", 64'(wr_pc_o), 64'd0);
        check("rst_wr_bta", 64'(wr_bta_o), 64'd0);
        check("rst_wr_type", 64'(wr_br_type_o), 64'd0);
    endtask

    task automatic step(input logic [N-1:0] v, input logic f, input bit fixed_pcs);
        int           g;
        logic [N-1:0] exp_ready;
        bit           exp_wen;
        @(negedge clk);
        rst         = 1'b0;
        flush_i     = f;
        req_valid_i = v;
        for (int k = 0; k < N; k++) begin
            req_pc_i[k]      = fixed_pcs ? 30'(64 * (k + 1)) : 30'($urandom);
            req_bta_i[k]     = 30'($urandom);
            req_br_type_i[k] = 2'($urandom_range(0, 3));
        end
        #1;
        g         = -1;
        exp_ready = '0;
        exp_wen   = 1'b0;
        if (m_sweep) begin
            check("sw_ready", 64'(req_ready_o), 64'd0);
            check("sw_busy", 64'(busy_o), 64'd1);
            check("sw_wr_en", 64'(wr_en_o), 64'd1);
            check("sw_wr_valid", 64'(wr_valid_o), 64'd0);
            check("sw_wr_pc", 64'(wr_pc_o), 64'(m_cnt * 2));
            check("sw_wr_bta", 64'(wr_bta_o), 64'd0);
            check("sw_wr_type", 64'(wr_br_type_o), 64'd0);
            if (f) m_cnt = 0;
            else if (m_cnt == (1 << AW) - 1) begin
                m_cnt   = 0;
                m_sweep = 1'b0;
            end else m_cnt++;
        end else begin
            if (!f && exp_q.size() < D) begin
                for (int i = 0; i < N; i++) begin
                    if (g < 0 && v[(m_rr + i) % N]) g = (m_rr + i) % N;
                end
            end
            if (g >= 0) exp_ready[g] = 1'b1;
            exp_wen = !f && (exp_q.size() > 0);
            check("run_ready", 64'(req_ready_o), 64'(exp_ready));
            check("run_busy", 64'(busy_o), 64'd0);
            check("run_wr_en", 64'(wr_en_o), 64'(exp_wen));
            if (exp_wen) begin
                check("run_wr_valid", 64'(wr_valid_o), 64'd1);
                check("run_wr_entry", 64'({wr_pc_o, wr_bta_o, wr_br_type_o}), 64'(exp_q[0]));
            end
            if (f) begin
                exp_q.delete();
                m_sweep = 1'b1;
                m_cnt   = 0;
            end else begin
                if (exp_wen) void'(exp_q.pop_front());
                if (g >= 0) begin
                    exp_q.push_back({req_pc_i[g], req_bta_i[g], req_br_type_i[g]});
                    m_rr = (g + 1) % N;
                end
            end
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs();
        model_reset();
    endtask

    initial begin
        bit done;
        bit found;
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        model_reset();

        // Sweep after reset, then random traffic with occasional flushes.
        for (int i = 0; i < 10; i++) step(N'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) step(N'($urandom), ($urandom_range(0, 29) == 0), 1'b0);

        // Both requesters hammering with fixed pcs: alternating grants.
        for (int i = 0; i < 20; i++) step('1, 1'b0, 1'b1);

        // Flush in RUN, then flush again mid-sweep at index 5.
        step('1, 1'b1, 1'b1);
        done = 1'b0;
        for (int i = 0; i < 25; i++) begin
            logic f;
            f = m_sweep && (m_cnt == 5) && !done;
            if (f) done = 1'b1;
            step(N'($urandom), f, 1'b0);
        end
        check("flush_at_5_hit", 64'(done), 64'd1);

        // Asynchronous reset while an update is pending.
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            step(N'($urandom), 1'b0, 1'b0);
            found = !m_sweep && (exp_q.size() > 0);
        end
        check("pending_before_rst", 64'(found), 64'd1);
        async_reset();
        for (int i = 0; i < 200; i++) step(N'($urandom), ($urandom_range(0, 39) == 0), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
